sel_range_writer: RTL
=====================

Name: sel_range_writer

Overview:
- Runtime-indexed part-select writer. Applies descending part-select writes (vec[index -: width] = data) into a VEC_W-bit register, one bit per cycle.
- Bits addressed outside [0, VEC_W-1] are discarded and flagged; in-range bits of a partially overlapping select are still written.
- Includes a registered runtime bit-read port so a bench can check contents, including out-of-range reads.
- Pairs with runtime-range-select read tests as the write side of the same indexing semantics.

Parameters:
VEC_W, 44, width of the target register vector
IDX_W, 8, width of signed (two's-complement) index inputs
MAXW, 4, maximum part-select width per command
INIT, {VEC_W{1'b0}}, reset value of vec

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when valid&&ready at posedge clk
cmd_index  input  IDX_W  signed MSB index of the select
cmd_width  input  3  number of bits to write, legal 1..MAXW
cmd_data  input  MAXW  write data; data[width-1] goes to vec[index]
done  output  1  one-cycle pulse, command complete
done_oor  output  1  valid with done; 1 if any bit was skipped or the width was illegal
vec  output  VEC_W  current register contents
rd_index  input  IDX_W  signed bit index to read
rd_data  output  1  registered vec[rd_index]; 0 if out of range
rd_oor  output  1  registered; 1 if rd_index is out of range

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: vec=INIT, state=IDLE, cmd_ready=1, done=0, done_oor=0, rd_data=0, rd_oor=0.
- Reset mid-command aborts it: no done pulse, and vec returns to INIT.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch index, width and data.
  - If width is 0 or greater than MAXW: go to DONE with the oor sticky set; vec is unchanged.
  - Otherwise: cur=index, cnt=width-1, oor sticky cleared, go to WRITE.
- WRITE:
  - cmd_ready=0.
  - Each cycle, if 0 <= cur <= VEC_W-1 (signed compare), vec[cur] <= data_l[cnt]; otherwise set the oor sticky.
  - Then cur <= cur-1 and cnt <= cnt-1.
  - On the cycle where cnt==0, go to DONE.
- DONE:
  - done=1 and done_oor=sticky for exactly one cycle; cmd_ready=0.
  - Next state is IDLE.
- Latency and throughput:
  - Command accepted at edge N.
  - Bit writes occur at edges N+1 .. N+width.
  - done is high in the cycle after edge N+width.
  - The earliest next accept is at edge N+width+2.
  - Throughput is one command per width+2 cycles.
- Index arithmetic:
  - cur is held in IDX_W+1 bits signed, so decrementing below the most-negative index does not wrap into range.
  - A negative index is always out of range.
  - An index >= VEC_W is out of range.
- Read port:
  - rd_data and rd_oor update every cycle from the pre-edge vec.
  - A read of a bit written at the same edge returns the old value.
  - Read latency is 1 cycle, independent of FSM state.
- Other boundary rules:
  - cmd_valid during WRITE or DONE is ignored; no buffering.
  - A fully out-of-range command still takes width+2 cycles and reports done_oor=1.
  - cmd_data bits at or above width are ignored.

Decomposition:
- Shared package sel_range_pkg holds:
  - state enum {IDLE, WRITE, DONE}
  - default VEC_W/IDX_W/MAXW constants
  - an in_range(idx, VEC_W) function used by both the write path and the read path
- One sub-module, sel_range_rdport: registered bit read with out-of-range detection. It is instantiated once and reusable by the read-side test modules.

Test Plan:
1. Assert reset for 2 cycles, release -> vec=0, cmd_ready=1, done=0, rd_data=0, rd_oor=0.
2. Command index=1, width=2, data=2'b01 -> vec=44'h1; done high 3 cycles after accept; done_oor=0; cmd_ready low for 3 cycles.
3. Command index=43, width=1, data=1, then rd_index=43 -> vec[43]=1, rd_data=1 one cycle later, rd_oor=0.
4. Partial overlap:
   - Command index=0, width=2, data=2'b11 -> vec[0]=1 and bit -1 dropped; done_oor=1; done at accept+3.
   - Repeat with index=45, width=4, data=4'hF -> vec[43:42] set, done_oor=1.
5. Fully out of range, starting from a known vec value:
   - Command index=44, width=1 -> vec unchanged, done_oor=1.
   - Command index=-1, width=2 -> vec unchanged, done_oor=1.
   - Command width=0 -> done at accept+1, done_oor=1.
   - rd_index=44 -> rd_data=0, rd_oor=1; rd_index=-1 -> rd_data=0, rd_oor=1.
6. Start command index=10, width=4, data=4'hF; assert reset asynchronously mid-WRITE after 2 bit writes -> vec=0 immediately, no done pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/sel_range_writer_pkg.sv
// Shared definitions for the runtime part-select writer and its read port.
package sel_range_pkg;

    localparam int VEC_W_DEF = 44;
    localparam int IDX_W_DEF = 8;
    localparam int MAXW_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // True when a signed bit index addresses a real bit of a vec_w-bit vector.
    function automatic logic in_range(input int idx, input int vec_w);
        return (idx >= 0) && (idx < vec_w);
    endfunction

endpackage

// File: rtl/sel_range_writer_if.sv
// Command handshake between a command source and the part-select writer.
interface sel_range_writer_if #(
    parameter int IDX_W = 8,
    parameter int MAXW  = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic signed [IDX_W-1:0] cmd_index;
    logic [2:0]              cmd_width;
    logic [MAXW-1:0]         cmd_data;
    logic                    done;
    logic                    done_oor;

    modport master (
        output cmd_valid, cmd_index, cmd_width, cmd_data,
        input  cmd_ready, done, done_oor
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_width, cmd_data,
        output cmd_ready, done, done_oor
    );
endinterface

// File: rtl/sel_range_writer_rdport.sv
// Registered single-bit read of a vector with signed, range-checked index.
module sel_range_rdport
    import sel_range_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VEC_W-1:0]        vec,
    input  logic signed [IDX_W-1:0] rd_index,
    output logic                    rd_data,
    output logic                    rd_oor
);

    localparam int VIDX_W = $clog2(VEC_W);

    // Sample the addressed bit every cycle; out-of-range reads return 0 and flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= 1'b0;
            rd_oor  <= 1'b0;
        end else if (in_range(int'(rd_index), VEC_W)) begin
            rd_data <= vec[rd_index[VIDX_W-1:0]];
            rd_oor  <= 1'b0;
        end else begin
            rd_data <= 1'b0;
            rd_oor  <= 1'b1;
        end
    end

endmodule

// File: rtl/sel_range_writer.sv
// Writes vec[index -: width] = data one bit per cycle, dropping and flagging
// bits that fall outside the vector; includes a registered bit-read port.
module sel_range_writer
    import sel_range_pkg::*;
#(
    parameter int               VEC_W = VEC_W_DEF,
    parameter int               IDX_W = IDX_W_DEF,
    parameter int               MAXW  = MAXW_DEF,
    parameter logic [VEC_W-1:0] INIT  = {VEC_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    sel_range_writer_if.slave       cmd,
    output logic [VEC_W-1:0]        vec,
    input  logic signed [IDX_W-1:0] rd_index,
    output logic                    rd_data,
    output logic                    rd_oor
);

    localparam int VIDX_W = $clog2(VEC_W);
    localparam int CNT_W  = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic signed [IDX_W:0] CUR_ONE = 1;
    localparam logic [CNT_W-1:0]      CNT_ONE = 1;

    state_e                state;
    // One extra bit so walking down past the most-negative index never wraps.
    logic signed [IDX_W:0] cur;
    logic [CNT_W-1:0]      cnt;
    logic [MAXW-1:0]       data_l;
    logic                  oor;
    logic                  width_bad;

    assign width_bad    = (cmd.cmd_width == 3'd0) || (int'(cmd.cmd_width) > MAXW);
    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.done      = (state == DONE);
    assign cmd.done_oor  = (state == DONE) && oor;

    // Command FSM: accept, walk the select from MSB downwards, then pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            vec    <= INIT;
            cur    <= '0;
            cnt    <= '0;
            data_l <= '0;
            oor    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        data_l <= cmd.cmd_data;
                        if (width_bad) begin
                            oor   <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur   <= {cmd.cmd_index[IDX_W-1], cmd.cmd_index};
                            cnt   <= CNT_W'(cmd.cmd_width - 3'd1);
                            oor   <= 1'b0;
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (in_range(int'(cur), VEC_W)) begin
                        vec[cur[VIDX_W-1:0]] <= data_l[cnt];
                    end else begin
                        oor <= 1'b1;
                    end
                    cur <= cur - CUR_ONE;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sel_range_rdport #(
        .VEC_W(VEC_W),
        .IDX_W(IDX_W)
    ) u_rdport (
        .clk      (clk),
        .reset    (reset),
        .vec      (vec),
        .rd_index (rd_index),
        .rd_data  (rd_data),
        .rd_oor   (rd_oor)
    );

endmodule
